// File: rtl/control_register_file.sv
// CR0/CR2/CR3 control register file with reserved-index write detection,
// page-fault CR2 capture, task-switch CR3 load and a paging-cache flush req/ack.
module control_register_file #(
  parameter logic [31:0] CR0_WMASK          = 32'h8000_001F,
  parameter logic [31:0] CR0_RESET          = 32'h0000_0010,
  parameter int          CR3_BASE_LSB       = 12,
  parameter bit          TASK_SWITCH_SET_TS = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [2:0]  write_index,
  input  logic [31:0] write_data,
  input  logic [2:0]  read_index,
  output logic [31:0] read_data,
  output logic        write_error,
  input  logic        fault_valid,
  input  logic [31:0] fault_linear_address,
  input  logic        task_switch_valid,
  input  logic [31:0] task_switch_cr3,
  input  logic        clear_ts,
  output logic        flush_request,
  input  logic        flush_ack,
  output logic        PE,
  output logic        MP,
  output logic        EM,
  output logic        TS,
  output logic        ET,
  output logic        PG,
  output logic [19:0] page_directory_base,
  output logic        flush_state
);

  // Handshake: flush_request rises the cycle after a trigger and stays high
  // until a cycle with flush_ack=1 and no new trigger; that edge drops it.
  localparam logic FLUSH_IDLE    = 1'b0;
  localparam logic FLUSH_PENDING = 1'b1;

  localparam logic [31:0] CR3_MASK = ~((32'h1 << CR3_BASE_LSB) - 32'h1);

  logic [31:0] cr0_q, cr0_d;
  logic [31:0] cr2_q, cr2_d;
  logic [31:0] cr3_q, cr3_d;
  logic        write_error_q, write_error_d;
  logic        flush_state_q, flush_state_d;

  logic        sw_cr0, sw_cr2, sw_cr3;
  logic [31:0] ts_cr3_masked;
  logic        flush_trigger;

  always_comb begin
    sw_cr0        = write_enable && (write_index == 3'd0);
    sw_cr2        = write_enable && (write_index == 3'd2);
    sw_cr3        = write_enable && (write_index == 3'd3);
    ts_cr3_masked = task_switch_cr3 & CR3_MASK;
    // A software CR3 write always flushes; a task-switch load only if CR3 changes.
    flush_trigger = sw_cr3 || (task_switch_valid && (ts_cr3_masked != cr3_q));
  end

  always_comb begin
    cr0_d = cr0_q;
    if (sw_cr0) begin
      cr0_d = (write_data & CR0_WMASK) | (cr0_q & ~CR0_WMASK);
    end
    if (clear_ts) begin
      cr0_d[3] = 1'b0;
    end
    if (task_switch_valid && TASK_SWITCH_SET_TS) begin
      cr0_d[3] = 1'b1;
    end

    cr2_d = cr2_q;
    if (fault_valid) begin
      cr2_d = fault_linear_address;
    end else if (sw_cr2) begin
      cr2_d = write_data;
    end

    cr3_d = cr3_q;
    if (task_switch_valid) begin
      cr3_d = ts_cr3_masked;
    end else if (sw_cr3) begin
      cr3_d = write_data & CR3_MASK;
    end

    write_error_d = write_enable && !(sw_cr0 || sw_cr2 || sw_cr3);
  end

  always_comb begin
    flush_state_d = flush_state_q;
    case (flush_state_q)
      FLUSH_IDLE: begin
        if (flush_trigger) flush_state_d = FLUSH_PENDING;
      end
      FLUSH_PENDING: begin
        if (flush_ack && !flush_trigger) flush_state_d = FLUSH_IDLE;
      end
      default: flush_state_d = FLUSH_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cr0_q         <= CR0_RESET;
      cr2_q         <= 32'h0;
      cr3_q         <= 32'h0;
      write_error_q <= 1'b0;
      flush_state_q <= FLUSH_IDLE;
    end else begin
      cr0_q         <= cr0_d;
      cr2_q         <= cr2_d;
      cr3_q         <= cr3_d;
      write_error_q <= write_error_d;
      flush_state_q <= flush_state_d;
    end
  end

  always_comb begin
    case (read_index)
      3'd0:    read_data = cr0_q;
      3'd2:    read_data = cr2_q;
      3'd3:    read_data = cr3_q;
      default: read_data = 32'h0;
    endcase
  end

  assign write_error         = write_error_q;
  assign flush_request       = (flush_state_q == FLUSH_PENDING);
  assign flush_state         = flush_state_q;
  assign PE                  = cr0_q[0];
  assign MP                  = cr0_q[1];
  assign EM                  = cr0_q[2];
  assign TS                  = cr0_q[3];
  assign ET                  = cr0_q[4];
  assign PG                  = cr0_q[31];
  assign page_directory_base = cr3_q[31:12];

endmodule

// File: tb/tb_control_register_file.sv
// Bench for control_register_file: an architectural model (register array
// plus a pending-flush flag) checked every cycle, plus directed literal checks.
module tb_control_register_file;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        write_enable = 1'b0;
  logic [2:0]  write_index = 3'd0;
  logic [31:0] write_data = 32'h0;
  logic [2:0]  read_index = 3'd0;
  logic [31:0] read_data;
  logic        write_error;
  logic        fault_valid = 1'b0;
  logic [31:0] fault_linear_address = 32'h0;
  logic        task_switch_valid = 1'b0;
  logic [31:0] task_switch_cr3 = 32'h0;
  logic        clear_ts = 1'b0;
  logic        flush_request;
  logic        flush_ack = 1'b0;
  logic        PE, MP, EM, TS, ET, PG;
  logic [19:0] page_directory_base;
  logic        flush_state;

  int n_cmp = 0;
  int n_bad = 0;

  control_register_file dut (
    .clock(clock), .reset(reset),
    .write_enable(write_enable), .write_index(write_index), .write_data(write_data),
    .read_index(read_index), .read_data(read_data), .write_error(write_error),
    .fault_valid(fault_valid), .fault_linear_address(fault_linear_address),
    .task_switch_valid(task_switch_valid), .task_switch_cr3(task_switch_cr3),
    .clear_ts(clear_ts), .flush_request(flush_request), .flush_ack(flush_ack),
    .PE(PE), .MP(MP), .EM(EM), .TS(TS), .ET(ET), .PG(PG),
    .page_directory_base(page_directory_base), .flush_state(flush_state)
  );

  // clock/reset block
  always #5 clock = ~clock;

  // Architectural model: CRn as an 8-entry array, unimplemented entries stay 0.
  localparam logic [31:0] WMASK = 32'h8000_001F;
  localparam logic [31:0] BMASK = 32'hFFFF_F000;
  logic [31:0] m_cr [0:7];
  bit          m_pend;
  bit          m_werr;

  always @(posedge clock or negedge reset) begin
    logic [31:0] nxt [0:7];
    bit trig;
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_cr[i] = 32'h0;
      m_cr[0] = 32'h0000_0010;
      m_pend  = 1'b0;
      m_werr  = 1'b0;
    end else begin
      nxt    = m_cr;
      m_werr = 1'b0;
      trig   = 1'b0;
      if (write_enable) begin
        case (write_index)
          3'd0: nxt[0] = (write_data & WMASK) | (m_cr[0] & ~WMASK);
          3'd2: nxt[2] = write_data;
          3'd3: begin nxt[3] = write_data & BMASK; trig = 1'b1; end
          default: m_werr = 1'b1;
        endcase
      end
      if (fault_valid) nxt[2] = fault_linear_address;
      if (clear_ts) nxt[0][3] = 1'b0;
      if (task_switch_valid) begin
        nxt[3] = task_switch_cr3 & BMASK;
        nxt[0][3] = 1'b1;
        if ((task_switch_cr3 & BMASK) != m_cr[3]) trig = 1'b1;
      end
      if (trig) m_pend = 1'b1;
      else if (flush_ack) m_pend = 1'b0;
      m_cr = nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare process: every cycle out of reset, on the falling edge
  always @(negedge clock) begin
    if (reset) begin
      chk("model_read_data", read_data, m_cr[read_index]);
      chk("model_write_error", {31'h0, write_error}, {31'h0, m_werr});
      chk("model_flush_request", {31'h0, flush_request}, {31'h0, m_pend});
      chk("model_cr0_bits", {26'h0, PG, ET, TS, EM, MP, PE},
          {26'h0, m_cr[0][31], m_cr[0][4], m_cr[0][3], m_cr[0][2], m_cr[0][1], m_cr[0][0]});
      chk("model_pdb", {12'h0, page_directory_base}, {12'h0, m_cr[3][31:12]});
    end
  end

  // driver tasks
  task automatic idle();
    write_enable = 1'b0; write_index = 3'd0; write_data = 32'h0;
    fault_valid = 1'b0; fault_linear_address = 32'h0;
    task_switch_valid = 1'b0; task_switch_cr3 = 32'h0;
    clear_ts = 1'b0; flush_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic sw_write(input logic [2:0] idx, input logic [31:0] data);
    write_enable = 1'b1; write_index = idx; write_data = data;
  endtask

  task automatic rd(input logic [2:0] idx, input string name, input logic [31:0] exp);
    read_index = idx;
    #1;
    chk(name, read_data, exp);
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clock);
    #2;
    rd(3'd0, "reset_cr0", 32'h0000_0010);
    chk("reset_et", {31'h0, ET}, 32'h1);
    chk("reset_pg", {31'h0, PG}, 32'h0);
    chk("reset_flush", {31'h0, flush_request}, 32'h0);
    rd(3'd5, "reset_read_idx5", 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    sw_write(3'd0, 32'hFFFF_FFFF); tick();
    rd(3'd0, "cr0_masked", 32'h8000_001F);
    chk("cr0_pe_pg", {30'h0, PE, PG}, 32'h3);

    sw_write(3'd1, 32'hA5A5_A5A5); tick();
    chk("werr_pulse", {31'h0, write_error}, 32'h1);
    rd(3'd1, "read_idx1", 32'h0);
    tick();
    chk("werr_one_cycle", {31'h0, write_error}, 32'h0);

    sw_write(3'd3, 32'h1234_5ABC); tick();
    rd(3'd3, "cr3_masked", 32'h1234_5000);
    chk("pdb", {12'h0, page_directory_base}, 32'h0001_2345);
    chk("flush_raised", {31'h0, flush_request}, 32'h1);
    repeat (3) tick();
    chk("flush_held", {31'h0, flush_request}, 32'h1);
    flush_ack = 1'b1; tick();
    chk("flush_dropped", {31'h0, flush_request}, 32'h0);

    clear_ts = 1'b1; tick();
    chk("clts", {31'h0, TS}, 32'h0);
    task_switch_valid = 1'b1; task_switch_cr3 = 32'h1234_5FFF; tick();
    chk("ts_same_no_flush", {31'h0, flush_request}, 32'h0);
    chk("ts_same_sets_ts", {31'h0, TS}, 32'h1);

    task_switch_valid = 1'b1; task_switch_cr3 = 32'hABCD_E123; tick();
    chk("ts_diff_flush", {31'h0, flush_request}, 32'h1);
    rd(3'd3, "ts_diff_cr3", 32'hABCD_E000);
    flush_ack = 1'b1; sw_write(3'd3, 32'h0000_1FFF); tick();
    chk("ack_with_rearm", {31'h0, flush_request}, 32'h1);
    rd(3'd3, "rearm_cr3", 32'h0000_1000);
    flush_ack = 1'b1; tick();
    chk("ack_after_rearm", {31'h0, flush_request}, 32'h0);

    fault_valid = 1'b1; fault_linear_address = 32'hDEAD_BEEF;
    sw_write(3'd2, 32'h1111_1111); tick();
    rd(3'd2, "fault_beats_write", 32'hDEAD_BEEF);
    sw_write(3'd2, 32'h1111_1111); tick();
    rd(3'd2, "cr2_write", 32'h1111_1111);

    clear_ts = 1'b1; tick();
    clear_ts = 1'b1; task_switch_valid = 1'b1; task_switch_cr3 = 32'h0000_1000; tick();
    chk("ts_beats_clts", {31'h0, TS}, 32'h1);
    chk("ts_same_cr3_idle", {31'h0, flush_request}, 32'h0);

    sw_write(3'd0, 32'h7FFF_FFE0); tick();
    rd(3'd0, "cr0_clear_masked", 32'h0);
    sw_write(3'd0, 32'h0000_0003); tick();
    chk("cr0_pe_mp", {30'h0, MP, PE}, 32'h3);

    flush_ack = 1'b1; tick();
    chk("ack_idle_ignored", {31'h0, flush_request}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      sw_write(3'(i + 2), 32'(i) * 32'h1357_9BDF); tick();
    end
    tick();

    sw_write(3'd3, 32'h5555_5555); tick();
    chk("pending_before_reset", {31'h0, flush_request}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_flush", {31'h0, flush_request}, 32'h0);
    rd(3'd3, "async_reset_cr3", 32'h0);
    rd(3'd0, "async_reset_cr0", 32'h0000_0010);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) tick();
    chk("post_reset_flush", {31'h0, flush_request}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
